// File: rtl/song_seq_ctrl.sv
// Note-event sequencer: fetches {code, beats} words from a synchronous ROM and holds each code for its beat count.
// Optional build macro SONG_GAP_EN inserts one silent beat after every note.
module song_seq_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int TICK_DIV   = 1500000,
    parameter int START_ADDR = 0
) (
    input  logic              clk_6MHz,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [3:0]        high,
    output logic [3:0]        med,
    output logic [3:0]        low,
    output logic              busy,
    output logic              done
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_PLAY   = 3'd3,
        S_PAUSED = 3'd4
`ifdef SONG_GAP_EN
        , S_GAP  = 3'd5
`endif
    } state_t;

    state_t               r_state, w_state_next;
    state_t               r_resume, w_resume_next;
    logic [11:0]          r_cur, w_cur_next;
    logic [3:0]           r_beats, w_beats_next;
    logic [PRESC_W-1:0]   r_presc, w_presc_next;
    logic [ADDR_W-1:0]    r_addr, w_addr_next;
    logic [11:0]          r_out, w_out_next;
    logic                 r_busy;
    logic                 r_done, w_done_next;

    logic                 w_tick;
    logic                 w_last;
    logic                 w_play_cmd;

    assign w_tick     = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_last     = w_tick && (r_beats == 4'd1);
    // pause outranks play when both arrive together
    assign w_play_cmd = play & ~pause;

    always_comb begin
        w_state_next  = r_state;
        w_resume_next = r_resume;
        w_cur_next    = r_cur;
        w_beats_next  = r_beats;
        w_presc_next  = r_presc;
        w_addr_next   = r_addr;
        w_out_next    = r_out;
        w_done_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_out_next = '0;
                if (w_play_cmd) begin
                    w_addr_next  = ADDR_W'(START_ADDR);
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (rom_data[3:0] != 4'd0) begin
                    w_cur_next   = rom_data[15:4];
                    w_beats_next = rom_data[3:0];
                    w_presc_next = '0;
                    w_out_next   = rom_data[15:4];
                    w_state_next = S_PLAY;
                end else if (loop) begin
                    w_addr_next  = ADDR_W'(START_ADDR);
                    w_state_next = S_FETCH;
                end else begin
                    w_done_next  = 1'b1;
                    w_out_next   = '0;
                    w_state_next = S_IDLE;
                end
            end
            S_PLAY: begin
                w_presc_next = w_tick ? '0 : r_presc + PRESC_W'(1);
                if (w_tick) begin
                    w_beats_next = r_beats - 4'd1;
                end
                if (w_last) begin
                    w_addr_next = r_addr + ADDR_W'(1);
`ifdef SONG_GAP_EN
                    w_state_next = S_GAP;
                    w_out_next   = '0;
`else
                    w_state_next = S_FETCH;
`endif
                end
                // The pause cycle itself is still counted, so resume picks up exactly where it left off.
                if (pause) begin
                    w_resume_next = w_state_next;
                    w_state_next  = S_PAUSED;
                    w_out_next    = '0;
                end
            end
`ifdef SONG_GAP_EN
            S_GAP: begin
                w_presc_next = w_tick ? '0 : r_presc + PRESC_W'(1);
                if (w_tick) begin
                    w_state_next = S_FETCH;
                end
                if (pause) begin
                    w_resume_next = w_state_next;
                    w_state_next  = S_PAUSED;
                end
            end
`endif
            S_PAUSED: begin
                w_out_next = '0;
                if (w_play_cmd) begin
                    w_state_next = r_resume;
                    w_out_next   = (r_resume == S_PLAY) ? r_cur : 12'd0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_out_next   = '0;
            end
        endcase

        if (stop) begin
            w_state_next = S_IDLE;
            w_addr_next  = ADDR_W'(START_ADDR);
            w_out_next   = '0;
            w_done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_6MHz) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_resume <= S_PLAY;
            r_cur    <= '0;
            r_beats  <= '0;
            r_presc  <= '0;
            r_addr   <= ADDR_W'(START_ADDR);
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_resume <= w_resume_next;
            r_cur    <= w_cur_next;
            r_beats  <= w_beats_next;
            r_presc  <= w_presc_next;
            r_addr   <= w_addr_next;
            r_out    <= w_out_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_done   <= w_done_next;
        end
    end

    assign rom_addr = r_addr;
    assign high     = r_out[11:8];
    assign med      = r_out[7:4];
    assign low      = r_out[3:0];
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_song_seq_ctrl.sv
// Directed bench for song_seq_ctrl with TICK_DIV=4, ADDR_W=3 and a registered-read note ROM model.
module tb_song_seq_ctrl;

`ifdef SONG_GAP_EN
    localparam int GAPC = 4;
`else
    localparam int GAPC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        play = 1'b0, pause = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [2:0]  rom_addr;
    logic [15:0] rom_data = 16'd0;
    logic [3:0]  high, med, low;
    logic        busy, done;
    logic [15:0] rom [0:7];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    song_seq_ctrl #(.ADDR_W(3), .TICK_DIV(4), .START_ADDR(0)) dut (
        .clk_6MHz (clk),
        .rst      (rst),
        .play     (play),
        .pause    (pause),
        .stop     (stop),
        .loop     (loop),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .high     (high),
        .med      (med),
        .low      (low),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        play  = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        if (done) done_cnt++;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        done_cnt = 0;
    endtask

    function automatic logic [31:0] code();
        return {20'd0, high, med, low};
    endfunction

    initial begin
        int p;
        int q;

        // Song 1: one 2-beat note then end marker
        for (int i = 0; i < 8; i++) rom[i] = 16'd0;
        rom[0] = {12'h003, 4'd2};
        loop = 1'b0;
        do_reset();
        chk("rst_code", code(), 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", {29'd0, rom_addr}, 32'd0);
        play = 1'b1;
        to_cycle(1);
        chk("t1_busy_c1", {31'd0, busy}, 32'd1);
        chk("t1_silent_c1", code(), 32'h0);
        to_cycle(3);
        chk("t1_code_c3", code(), 32'h003);
        to_cycle(10);
        chk("t1_code_c10", code(), 32'h003);
        chk("t1_addr_c10", {29'd0, rom_addr}, 32'd0);
        to_cycle(11);
        chk("t1_addr_c11", {29'd0, rom_addr}, 32'd1);
        to_cycle(12 + GAPC);
        chk("t1_nodone_early", {31'd0, done}, 32'd0);
        to_cycle(13 + GAPC);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        chk("t1_silent_end", code(), 32'h0);
        to_cycle(20 + GAPC);
        chk("t1_done_once", done_cnt, 32'd1);

        // Same song looping, then stop+pause together during a note
        loop = 1'b1;
        do_reset();
        p = 12 + GAPC;
        play = 1'b1;
        to_cycle(11);
        chk("t2_addr_c11", {29'd0, rom_addr}, 32'd1);
        to_cycle(13 + GAPC);
        chk("t2_addr_restart", {29'd0, rom_addr}, 32'd0);
        to_cycle(3 + p);
        chk("t2_code_rep", code(), 32'h003);
        to_cycle(10 + p);
        chk("t2_addr_rep_hold", {29'd0, rom_addr}, 32'd0);
        to_cycle(11 + p);
        chk("t2_addr_rep_adv", {29'd0, rom_addr}, 32'd1);
        to_cycle(4 + 3 * p);
        chk("t2_code_before_stop", code(), 32'h003);
        stop  = 1'b1;
        pause = 1'b1;
        to_cycle(5 + 3 * p);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_addr", {29'd0, rom_addr}, 32'd0);
        chk("t4_silent", code(), 32'h0);
        to_cycle(11 + 3 * p);
        chk("t4_no_done", done_cnt, 32'd0);
        chk("t4_still_idle", {31'd0, busy}, 32'd0);

        // Pause three cycles into a 1-beat note, resume ten cycles later
        rom[0] = {12'h003, 4'd1};
        loop = 1'b0;
        do_reset();
        play = 1'b1;
        to_cycle(5);
        chk("t3_code_prepause", code(), 32'h003);
        pause = 1'b1;
        to_cycle(6);
        chk("t3_silent_paused", code(), 32'h0);
        chk("t3_busy_paused", {31'd0, busy}, 32'd1);
        to_cycle(15);
        chk("t3_silent_late", code(), 32'h0);
        chk("t3_addr_frozen", {29'd0, rom_addr}, 32'd0);
        play = 1'b1;
        to_cycle(16);
        chk("t3_code_resumed", code(), 32'h003);
        chk("t3_addr_resumed", {29'd0, rom_addr}, 32'd0);
        to_cycle(17);
        chk("t3_addr_next", {29'd0, rom_addr}, 32'd1);
        to_cycle(19 + GAPC);
        chk("t3_done", {31'd0, done}, 32'd1);

        // Eight 1-beat notes fill the ROM: address wraps 7 -> 0
        for (int i = 0; i < 8; i++) rom[i] = {12'h0A0 + 12'(i), 4'd1};
        do_reset();
        q = 6 + GAPC;
        play = 1'b1;
        to_cycle(3 + 7 * q);
        chk("t5_code_n7", code(), 32'h0A7);
        chk("t5_addr_n7", {29'd0, rom_addr}, 32'd7);
        to_cycle(7 + 7 * q);
        chk("t5_addr_wrap", {29'd0, rom_addr}, 32'd0);
        to_cycle(3 + 8 * q);
        chk("t5_code_wrapped", code(), 32'h0A0);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_no_done", done_cnt, 32'd0);
        stop = 1'b1;
        step();

`ifdef SONG_GAP_EN
        // Two repeated 1-beat notes separated by a silent beat
        for (int i = 0; i < 8; i++) rom[i] = 16'd0;
        rom[0] = {12'h010, 4'd1};
        rom[1] = {12'h010, 4'd1};
        do_reset();
        play = 1'b1;
        to_cycle(6);
        chk("t6_code_n0", code(), 32'h010);
        to_cycle(7);
        chk("t6_gap_start", code(), 32'h0);
        chk("t6_addr", {29'd0, rom_addr}, 32'd1);
        to_cycle(10);
        chk("t6_gap_end", code(), 32'h0);
        to_cycle(13);
        chk("t6_code_n1", code(), 32'h010);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
